// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - lsu_op_e    : request opcode encoding carried on req_op
//   - lsu_state_e : control FSM state encoding
//   - lsu_is_load / lsu_is_misaligned : opcode classification helpers
`timescale 1ns/1ps
package lsu_pkg;

    typedef enum logic [2:0] {
        OpLw  = 3'd0,
        OpLh  = 3'd1,
        OpLhu = 3'd2,
        OpLb  = 3'd3,
        OpLbu = 3'd4,
        OpSw  = 3'd5,
        OpSh  = 3'd6,
        OpSb  = 3'd7
    } lsu_op_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRd   = 2'd1,
        StWr   = 2'd2,
        StResp = 2'd3
    } lsu_state_e;

    function automatic logic lsu_is_load(lsu_op_e op);
        return (op == OpLw) || (op == OpLh) || (op == OpLhu) ||
               (op == OpLb) || (op == OpLbu);
    endfunction

    // Words need offset 0, halfwords an even offset; bytes are never misaligned.
    function automatic logic lsu_is_misaligned(lsu_op_e op, logic [1:0] offset);
        logic w_mis;
        w_mis = 1'b0;
        case (op)
            OpLw, OpSw:        w_mis = (offset != 2'b00);
            OpLh, OpLhu, OpSh: w_mis = offset[0];
            default:           w_mis = 1'b0;
        endcase
        return w_mis;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational byte-lane logic for the load/store unit.
//   i_op          : operation being performed
//   i_offset      : byte offset within the word (byte address [1:0])
//   i_rdata       : word read from data memory
//   i_wdata       : right-justified store data
//   o_load_data   : addressed lane(s) of i_rdata, sign/zero extended
//   o_store_word  : word to write back (i_rdata with lane(s) replaced, or i_wdata for SW)
`timescale 1ns/1ps
module lsu_align
    import lsu_pkg::*;
(
    input  lsu_op_e     i_op,
    input  logic [1:0]  i_offset,
    input  logic [31:0] i_rdata,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load_data,
    output logic [31:0] o_store_word
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [4:0]  w_bit_pos;

    assign w_bit_pos = {i_offset, 3'b000};
    assign w_byte    = i_rdata[w_bit_pos +: 8];
    assign w_half    = i_offset[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        o_load_data = 32'h0;
        unique case (i_op)
            OpLw:    o_load_data = i_rdata;
            OpLh:    o_load_data = {{16{w_half[15]}}, w_half};
            OpLhu:   o_load_data = {16'h0, w_half};
            OpLb:    o_load_data = {{24{w_byte[7]}}, w_byte};
            OpLbu:   o_load_data = {24'h0, w_byte};
            default: o_load_data = 32'h0;
        endcase
    end

    always_comb begin
        o_store_word = i_rdata;
        unique case (i_op)
            OpSw: o_store_word = i_wdata;
            OpSh: begin
                if (i_offset[1]) begin
                    o_store_word[31:16] = i_wdata[15:0];
                end else begin
                    o_store_word[15:0] = i_wdata[15:0];
                end
            end
            OpSb:    o_store_word[w_bit_pos +: 8] = i_wdata[7:0];
            default: o_store_word = i_rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store unit toward a word-wide data memory.
//   clk, rst        : clock, asynchronous active-high reset
//   req_*           : request handshake (valid/ready), opcode, byte address, store data
//   resp_valid/err  : one-cycle completion pulse, misalignment flag
//   load_data       : extended load result, valid with resp_valid
//   mem_*           : word address, write data, read/write strobes, read data (same cycle)
// Sub-word stores do a read-modify-write: RD captures the word, WR writes the merged word.
`timescale 1ns/1ps
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [ADDR_W+1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [31:0]       load_data,
    output logic [ADDR_W-1:0] mem_adress,
    output logic [31:0]       mem_write_data,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [31:0]       mem_read_data
);

    lsu_state_e        r_state;
    lsu_state_e        w_state_next;
    lsu_op_e           r_op;
    logic [ADDR_W+1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdata;
    logic              r_err;

    lsu_op_e           w_req_op;
    logic              w_req_mis;
    logic [31:0]       w_load_data;
    logic [31:0]       w_store_word;

    assign w_req_op  = lsu_op_e'(req_op);
    assign w_req_mis = lsu_is_misaligned(w_req_op, req_addr[1:0]);

    lsu_align u_align (
        .i_op         (r_op),
        .i_offset     (r_addr[1:0]),
        .i_rdata      (r_rdata),
        .i_wdata      (r_wdata),
        .o_load_data  (w_load_data),
        .o_store_word (w_store_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_op    <= OpLw;
            r_addr  <= '0;
            r_wdata <= 32'h0;
            r_rdata <= 32'h0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            // Requests are only captured while idle; req_valid elsewhere is ignored.
            if (r_state == StIdle && req_valid) begin
                r_op    <= w_req_op;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_err   <= w_req_mis;
            end
            if (r_state == StRd) begin
                r_rdata <= mem_read_data;
            end
        end
    end

    always_comb begin
        w_state_next   = r_state;
        req_ready      = 1'b0;
        resp_valid     = 1'b0;
        resp_err       = 1'b0;
        load_data      = 32'h0;
        mem_adress     = '0;
        mem_write_data = 32'h0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        unique case (r_state)
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (w_req_mis) begin
                        w_state_next = StResp;
                    end else if (w_req_op == OpSw) begin
                        w_state_next = StWr;
                    end else begin
                        w_state_next = StRd;
                    end
                end
            end
            StRd: begin
                mem_read     = 1'b1;
                mem_adress   = r_addr[ADDR_W+1:2];
                w_state_next = lsu_is_load(r_op) ? StResp : StWr;
            end
            StWr: begin
                mem_write      = 1'b1;
                mem_adress     = r_addr[ADDR_W+1:2];
                mem_write_data = w_store_word;
                w_state_next   = StResp;
            end
            StResp: begin
                resp_valid   = 1'b1;
                resp_err     = r_err;
                load_data    = (!r_err && lsu_is_load(r_op)) ? w_load_data : 32'h0;
                w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
`timescale 1ns/1ps
module tb_load_store_unit;

    localparam int ADDR_W = 18;
    localparam logic [2:0] LW = 3'd0, LH = 3'd1, LHU = 3'd2, LB = 3'd3, LBU = 3'd4;
    localparam logic [2:0] SW = 3'd5, SH = 3'd6, SB = 3'd7;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_op;
    logic [ADDR_W+1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_err;
    logic [31:0]       load_data;
    logic [ADDR_W-1:0] mem_adress;
    logic [31:0]       mem_write_data;
    logic              mem_read;
    logic              mem_write;
    logic [31:0]       mem_read_data;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(ADDR_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_op         (req_op),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_err       (resp_err),
        .load_data      (load_data),
        .mem_adress     (mem_adress),
        .mem_write_data (mem_write_data),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_read_data  (mem_read_data)
    );

    // ---------------- environment data memory ----------------
    logic [31:0] env_mem [16];
    logic        init_mem;

    function automatic logic [31:0] init_word(int i);
        if (i == 5) return 32'h8040_20F0;
        if (i == 2) return 32'hDEAD_BEEF;
        return 32'(i) * 32'h0101_0101;
    endfunction

    assign mem_read_data = env_mem[mem_adress[3:0]];

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 16; i++) env_mem[i] <= init_word(i);
        end else if (mem_write) begin
            env_mem[mem_adress[3:0]] <= mem_write_data;
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [16];

    function automatic logic ref_mis(logic [2:0] op, logic [ADDR_W+1:0] a);
        int off;
        off = int'(a[1:0]);
        if (op == LW || op == SW) return (off % 4) != 0;
        if (op == LH || op == LHU || op == SH) return (off % 2) != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(logic [2:0] op, logic [31:0] word, int off);
        logic [31:0] v;
        v = word >> (8 * off);
        case (op)
            LW:  return word;
            LH:  return ((v & 32'h8000) != 0) ? ((v & 32'hFFFF) | 32'hFFFF_0000) : (v & 32'hFFFF);
            LHU: return v & 32'hFFFF;
            LB:  return ((v & 32'h80) != 0) ? ((v & 32'hFF) | 32'hFFFF_FF00) : (v & 32'hFF);
            LBU: return v & 32'hFF;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] ref_store(logic [2:0] op, logic [31:0] word, int off,
                                              logic [31:0] wd);
        logic [31:0] mask;
        case (op)
            SW: return wd;
            SH: begin
                mask = 32'hFFFF << (8 * off);
                return (word & ~mask) | ((wd & 32'hFFFF) << (8 * off));
            end
            SB: begin
                mask = 32'hFF << (8 * off);
                return (word & ~mask) | ((wd & 32'hFF) << (8 * off));
            end
            default: return word;
        endcase
    endfunction

    // Expectations published by the driver, latched by the compare process at transfer.
    logic        e_err, e_rd, e_wr, e_lit, e_litw, done;
    logic [31:0] e_data, e_addr, e_wdata, e_lit_data, e_litw_data;
    int          e_lat;
    int          ops_issued;

    // ---------------- compare process ----------------
    int          checks = 0;
    int          errors = 0;
    logic        busy = 1'b0;
    int          n, rd_cnt, wr_cnt, xfers = 0;
    logic        c_err, c_rd, c_wr, c_lit, c_litw;
    logic [31:0] c_data, c_addr, c_wdata, c_lit_data, c_litw_data;
    int          c_lat;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (done) begin
            check("xfer_count", 32'(xfers), 32'(ops_issued));
            for (int i = 0; i < 16; i++) check("mem_final", env_mem[i], ref_mem[i]);
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end else if (rst) begin
            busy = 1'b0;
            check("rst_strobes", {28'h0, resp_valid, resp_err, mem_read, mem_write}, 32'h0);
            check("rst_load_data", load_data, 32'h0);
            check("rst_mem_adress", 32'(mem_adress), 32'h0);
            check("rst_mem_wdata", mem_write_data, 32'h0);
        end else begin
            check("rd_wr_excl", 32'(mem_read & mem_write), 32'h0);
            if (!mem_read && !mem_write) check("adr_idle", 32'(mem_adress), 32'h0);
            if (!mem_write) check("wdata_idle", mem_write_data, 32'h0);
            if (!resp_valid) check("resp_idle", {31'h0, resp_err} | load_data, 32'h0);
            check("req_ready", 32'(req_ready), 32'(!busy));
            if (busy) begin
                n++;
                if (mem_read) begin
                    rd_cnt++;
                    check("rd_addr", 32'(mem_adress), c_addr);
                end
                if (mem_write) begin
                    wr_cnt++;
                    check("wr_addr", 32'(mem_adress), c_addr);
                    check("wr_data", mem_write_data, c_wdata);
                    if (c_litw) check("wr_data_lit", mem_write_data, c_litw_data);
                end
                if (resp_valid) begin
                    check("resp_err", 32'(resp_err), 32'(c_err));
                    check("load_data", load_data, c_data);
                    if (c_lit) check("load_data_lit", load_data, c_lit_data);
                    check("latency", 32'(n), 32'(c_lat));
                    check("read_strobes", 32'(rd_cnt), 32'(c_rd));
                    check("write_strobes", 32'(wr_cnt), 32'(c_wr));
                    busy = 1'b0;
                end else if (n > 6) begin
                    check("resp_timeout", 32'(resp_valid), 32'h1);
                    busy = 1'b0;
                end
            end else begin
                check("spurious_activity", {29'h0, resp_valid, mem_read, mem_write}, 32'h0);
            end
            // Inputs are stable here; a transfer happens at the next rising edge.
            if (req_valid && req_ready) begin
                xfers++;
                busy   = 1'b1;
                n      = 0;
                rd_cnt = 0;
                wr_cnt = 0;
                c_err = e_err; c_rd = e_rd; c_wr = e_wr; c_data = e_data; c_lat = e_lat;
                c_addr = e_addr; c_wdata = e_wdata; c_lit = e_lit; c_lit_data = e_lit_data;
                c_litw = e_litw; c_litw_data = e_litw_data;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic setup_op(input logic [2:0] op, input logic [ADDR_W+1:0] a,
                            input logic [31:0] wd, input logic commit);
        int          off;
        logic [3:0]  wi;
        logic        mis;
        logic [31:0] nw;
        off = int'(a[1:0]);
        wi  = a[5:2];
        mis = ref_mis(op, a);
        e_err   = mis;
        e_rd    = !mis && (op != SW);
        e_wr    = !mis && (op >= SW);
        e_lat   = mis ? 1 : ((op == SH || op == SB) ? 3 : 2);
        e_data  = (mis || op >= SW) ? 32'h0 : ref_load(op, ref_mem[wi], off);
        e_addr  = 32'(a >> 2);
        nw      = ref_store(op, ref_mem[wi], off, wd);
        e_wdata = nw;
        if (commit && !mis && op >= SW) ref_mem[wi] = nw;
        req_op    = op;
        req_addr  = a;
        req_wdata = wd;
        req_valid = 1'b1;
        ops_issued++;
    endtask

    task automatic do_op(input logic [2:0] op, input logic [ADDR_W+1:0] a,
                         input logic [31:0] wd, input logic hold,
                         input logic lit, input logic [31:0] lit_data,
                         input logic litw, input logic [31:0] litw_data);
        int k;
        k = 0;
        while (!req_ready && k < 20) begin @(posedge clk); #2; k++; end
        e_lit = lit; e_lit_data = lit_data; e_litw = litw; e_litw_data = litw_data;
        setup_op(op, a, wd, 1'b1);
        @(posedge clk); #2;
        if (!hold) req_valid = 1'b0;
        k = 0;
        while (!resp_valid && k < 10) begin @(posedge clk); #2; k++; end
        req_valid = 1'b0;
        @(posedge clk); #2;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int k;
        rst = 1'b1; init_mem = 1'b1; done = 1'b0; ops_issued = 0;
        req_valid = 1'b0; req_op = 3'd0; req_addr = '0; req_wdata = 32'h0;
        e_err = 0; e_rd = 0; e_wr = 0; e_lit = 0; e_litw = 0; e_lat = 0;
        e_data = 0; e_addr = 0; e_wdata = 0; e_lit_data = 0; e_litw_data = 0;
        for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0; init_mem = 1'b0;
        @(posedge clk); #2;

        do_op(LB,  20'h14, 32'h0, 0, 1, 32'hFFFF_FFF0, 0, 32'h0);
        do_op(LBU, 20'h15, 32'h0, 0, 1, 32'h0000_0020, 0, 32'h0);
        do_op(LH,  20'h16, 32'h0, 0, 1, 32'hFFFF_8040, 0, 32'h0);
        do_op(LHU, 20'h16, 32'h0, 0, 1, 32'h0000_8040, 0, 32'h0);
        do_op(LH,  20'h15, 32'h0, 0, 1, 32'h0,         0, 32'h0);
        do_op(LW,  20'h14, 32'h0, 0, 1, 32'h8040_20F0, 0, 32'h0);
        do_op(LW,  20'h16, 32'h0, 0, 0, 32'h0,         0, 32'h0);
        do_op(SB,  20'h17, 32'hAB, 0, 0, 32'h0,        1, 32'hAB40_20F0);
        do_op(LW,  20'h14, 32'h0, 0, 1, 32'hAB40_20F0, 0, 32'h0);
        do_op(SH,  20'h14, 32'h1234_CAFE, 0, 0, 32'h0, 1, 32'hAB40_CAFE);
        do_op(LBU, 20'h14, 32'h0, 0, 1, 32'h0000_00FE, 0, 32'h0);
        do_op(SW,  20'h08, 32'h1234_5678, 0, 0, 32'h0, 1, 32'h1234_5678);
        do_op(LW,  20'h08, 32'h0, 1, 1, 32'h1234_5678, 0, 32'h0);
        do_op(SB,  20'h09, 32'h0000_0177, 0, 0, 32'h0, 1, 32'h1234_7778);
        do_op(LB,  20'h09, 32'h0, 0, 1, 32'h0000_0077, 0, 32'h0);
        do_op(SW,  20'h0A, 32'hFFFF_FFFF, 0, 1, 32'h0, 0, 32'h0);
        do_op(LHU, 20'h0A, 32'h0, 1, 1, 32'h0000_1234, 0, 32'h0);

        // SH aborted by reset while in WR: memory must keep its old word.
        e_lit = 0; e_litw = 0;
        setup_op(SH, 20'h0A, 32'h0000_5555, 1'b0);
        @(posedge clk); #2;
        req_valid = 1'b0;
        k = 0;
        while (!mem_write && k < 10) begin @(posedge clk); #2; k++; end
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #2;
        do_op(LW, 20'h08, 32'h0, 0, 1, 32'h1234_7778, 0, 32'h0);

        repeat (2) @(posedge clk);
        #2 done = 1'b1;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: ADDR_W, 18, word-address width toward data memory; byte address is ADDR_W+2 bits.
REQ-002 Port: clk  in  1  single clock; all state on rising edge.
REQ-003 Port: rst  in  1  asynchronous, active-high reset.
REQ-004 Port: req_valid  in  1  pipeline presents a memory op.
REQ-005 Port: req_ready  out  1  unit idle and accepting; transfer when req_valid and req_ready are both 1.
REQ-006 Port: req_op  in  3  0=LW 1=LH 2=LHU 3=LB 4=LBU 5=SW 6=SH 7=SB.
REQ-007 Port: req_addr  in  ADDR_W+2  byte address.
REQ-008 Port: req_wdata  in  32  store data, right-justified for SH/SB.
REQ-009 Port: resp_valid  out  1  one-cycle completion pulse.
REQ-010 Port: resp_err  out  1  misaligned access, valid with resp_valid.
REQ-011 Port: load_data  out  32  extended load result, valid with resp_valid.
REQ-012 Port: mem_adress  out  ADDR_W  word address to data memory (byte address bits [ADDR_W+1:2]).
REQ-013 Port: mem_write_data  out  32  word written to data memory.
REQ-014 Port: mem_read  out  1  data-memory read enable.
REQ-015 Port: mem_write  out  1  data-memory write enable.
REQ-016 Port: mem_read_data  in  32  word returned by data memory, valid in the same cycle mem_read is high.

Function
REQ-017 FSM states SHALL be IDLE, RD, WR, RESP; req_ready=1 only in IDLE.
REQ-018 On transfer the unit SHALL register op, addr, wdata and move: misaligned->RESP; LW/LH/LHU/LB/LBU->RD; SH/SB->RD; SW->WR.
REQ-019 Misaligned: LW/SW with addr[1:0]!=0, LH/LHU/SH with addr[0]!=0; no mem_read/mem_write SHALL be asserted; RESP with resp_err=1, load_data=0.
REQ-020 RD SHALL assert mem_read=1 for exactly one cycle and capture mem_read_data at its end; loads then go to RESP, SH/SB to WR.
REQ-021 WR SHALL assert mem_write=1 for exactly one cycle, then go to RESP.
REQ-022 RESP SHALL assert resp_valid=1 for exactly one cycle, then return to IDLE.
REQ-023 Latency from transfer edge: load 2 cycles to resp_valid, SW 2 cycles, SH/SB 3 cycles, misaligned 1 cycle.
REQ-024 Byte lanes are little-endian: byte offset k occupies bits [8k+7:8k]; halfword offset 0 is bits [15:0], offset 2 is bits [31:16].
REQ-025 LB/LH SHALL sign-extend, LBU/LHU SHALL zero-extend, LW returns the word unchanged.
REQ-026 SH/SB SHALL write the captured word with only the addressed lane(s) replaced by req_wdata[15:0]/[7:0]; SW writes req_wdata unchanged.
REQ-027 mem_adress SHALL hold the registered word address in RD and WR and be 0 otherwise; mem_write_data SHALL be 0 outside WR.
REQ-028 mem_read and mem_write SHALL never be high in the same cycle.
REQ-029 req_valid outside IDLE SHALL be ignored; the request is not captured.

Reset
REQ-030 rst=1 SHALL immediately force IDLE and drive resp_valid=0, resp_err=0, load_data=0, mem_read=0, mem_write=0, mem_adress=0, mem_write_data=0.
REQ-031 rst asserted during RD or WR SHALL abort the op with no further memory strobe; after release req_ready=1 on the first cycle.

Structure
REQ-032 Shared package lsu_pkg SHALL hold the req_op encodings and the FSM state encoding.
REQ-033 A purely combinational sub-module lsu_align SHALL perform lane extraction/extension (REQ-025) and lane merge (REQ-026); the FSM stays in load_store_unit.

Verification
REQ-034 Memory word 5 = 0x8040_20F0; LB at byte addr 0x14 -> resp_valid 2 cycles after transfer, load_data=0xFFFF_FFF0; LBU at 0x15 -> 0x0000_0020.
REQ-035 LH at 0x16 -> load_data=0xFFFF_8040; LHU at 0x16 -> 0x0000_8040; LH at 0x15 -> resp_err=1, load_data=0, no mem_read.
REQ-036 SB wdata=0xAB at 0x17 on word 0x8040_20F0 -> RD, WR, RESP; mem_write_data=0xAB40_20F0 with mem_write high one cycle; resp 3 cycles after transfer.
REQ-037 SW 0x1234_5678 at 0x08 then LW at 0x08 -> mem_adress=2, load_data=0x1234_5678; req_valid held high while busy -> no extra op accepted.
REQ-038 rst pulsed during WR of an SH -> mem_write drops immediately, memory word unchanged, req_ready=1 after release, next LW succeeds.
